// File: rtl/pc_branch_sequencer.sv
// Program counter owner for a MIPS-style datapath: computes PC+4 and the branch
// target, resolves BEQ/BNE/J, raises a one-cycle flush after each redirect and keeps saturating branch statistics.
module pc_branch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_eq,
  input  logic             branch_ne,
  input  logic             zero,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic [31:0]      imm_ext,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [31:0]      branch_target,
  output logic             flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic             state_dbg
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state;
  logic [31:0] imm_shift;
  logic [31:0] jump_target;
  logic        cond;
  logic        is_branch;
  logic        unused_imm_hi;

  // imm_ext[31:30] fall off the top of the word-offset shift.
  assign unused_imm_hi = ^imm_ext[31:30];
  assign imm_shift     = {imm_ext[29:0], 2'b00};
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + imm_shift;
  assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};
  assign cond          = (branch_eq & zero) | (branch_ne & ~zero);
  assign is_branch     = branch_eq | branch_ne;
  assign state_dbg     = (state == FLUSH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      state      <= RUN;
      flush      <= 1'b0;
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (!stall) begin
      case (state)
        RUN: begin
          if (is_branch && branch_cnt != CNT_MAX)
            branch_cnt <= branch_cnt + CNT_ONE;
          if (jump || cond) begin
            pc    <= jump ? jump_target : branch_target;
            state <= FLUSH;
            flush <= 1'b1;
            if (taken_cnt != CNT_MAX)
              taken_cnt <= taken_cnt + CNT_ONE;
          end else begin
            pc <= pc_plus4;
          end
        end
        FLUSH: begin
          // Wrong-path instruction: its control inputs are ignored.
          pc    <= pc_plus4;
          state <= RUN;
          flush <= 1'b0;
        end
        default: begin
          state <= RUN;
          flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Self-checking bench for pc_branch_sequencer: directed scenarios plus randomized
// traffic against a behavioural PC model; a second instance with CNT_W=2 exercises saturation.
module tb_pc_branch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, branch_eq, branch_ne, zero, jump;
  logic [25:0] jump_index;
  logic [31:0] imm_ext;

  logic [31:0] pc, pc_plus4, branch_target;
  logic        flush, state_dbg;
  logic [15:0] branch_cnt, taken_cnt;

  logic [31:0] pc2, pc_plus4_2, branch_target2;
  logic        flush2, state_dbg2;
  logic [1:0]  branch_cnt2, taken_cnt2;

  pc_branch_sequencer #(.RESET_PC(RST_PC), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_eq(branch_eq),
    .branch_ne(branch_ne), .zero(zero), .jump(jump), .jump_index(jump_index),
    .imm_ext(imm_ext), .pc(pc), .pc_plus4(pc_plus4), .branch_target(branch_target),
    .flush(flush), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt), .state_dbg(state_dbg)
  );

  pc_branch_sequencer #(.RESET_PC(RST_PC), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_eq(branch_eq),
    .branch_ne(branch_ne), .zero(zero), .jump(jump), .jump_index(jump_index),
    .imm_ext(imm_ext), .pc(pc2), .pc_plus4(pc_plus4_2), .branch_target(branch_target2),
    .flush(flush2), .branch_cnt(branch_cnt2), .taken_cnt(taken_cnt2), .state_dbg(state_dbg2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model: PC value, whether the next slot is a wrong-path slot, event counts
  logic [31:0] m_pc;
  logic        m_flush;
  int          m_b16, m_t16, m_b2, m_t2;

  // scoreboard of expected PCs for the randomized run
  logic [31:0] exp_q[$];

  function automatic logic [31:0] exp_branch(input logic [31:0] p, input logic [31:0] imm);
    return p + 32'd4 + imm * 32'd4;
  endfunction

  function automatic logic [31:0] exp_jump(input logic [31:0] p, input logic [25:0] idx);
    logic [31:0] seq;
    seq = p + 32'd4;
    return (seq & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
  endfunction

  function automatic int sat_inc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  task automatic model_edge();
    logic taken;
    if (!rst_n) begin
      m_pc = RST_PC; m_flush = 1'b0;
      m_b16 = 0; m_t16 = 0; m_b2 = 0; m_t2 = 0;
    end else if (!stall) begin
      if (m_flush) begin
        m_pc = m_pc + 32'd4;
        m_flush = 1'b0;
      end else begin
        taken = jump || (branch_eq && zero) || (branch_ne && !zero);
        if (branch_eq || branch_ne) begin
          m_b16 = sat_inc(m_b16, 65535);
          m_b2  = sat_inc(m_b2, 3);
        end
        if (taken) begin
          m_t16 = sat_inc(m_t16, 65535);
          m_t2  = sat_inc(m_t2, 3);
        end
        if (jump)        m_pc = exp_jump(m_pc, jump_index);
        else if (taken)  m_pc = exp_branch(m_pc, imm_ext);
        else             m_pc = m_pc + 32'd4;
        m_flush = taken;
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; stall = 1'b0; branch_eq = 1'b0; branch_ne = 1'b0;
    zero = 1'b0; jump = 1'b0; jump_index = '0; imm_ext = '0;
  endtask

  // Taken BEQ to target-4, then the flush slot advances to target (state RUN).
  task automatic land_at(input logic [31:0] target);
    logic [31:0] diff;
    idle_inputs();
    diff = target - 32'd4 - (m_pc + 32'd4);
    branch_eq = 1'b1; zero = 1'b1; imm_ext = diff >> 2;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0; stall = 1'b1; jump = 1'b1; branch_eq = 1'b1; zero = 1'b1;
    tick();
    n_checks++; if (pc !== 32'h0040_0000) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0040_0000); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", flush); end
    n_checks++; if (branch_cnt !== 16'd0 || taken_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", branch_cnt, taken_cnt); end
    n_checks++; if (branch_cnt2 !== 2'd0 || taken_cnt2 !== 2'd0) begin n_fail++; $display("FAIL reset_cnt2: got %0d/%0d want 0/0", branch_cnt2, taken_cnt2); end
    idle_inputs();
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++; if (pc !== 32'h0040_0000 + 32'(4 * i) || flush !== 1'b0) begin n_fail++; $display("FAIL seq_fetch%0d: got pc=%h flush=%b want pc=%h flush=0", i, pc, flush, 32'h0040_0000 + 32'(4 * i)); end
    end
  endtask

  task automatic test_taken_beq();
    tick();
    n_checks++; if (pc !== 32'h0040_0010) begin n_fail++; $display("FAIL beq_setup_pc: got %h want 00400010", pc); end
    branch_eq = 1'b1; zero = 1'b1; imm_ext = 32'hFFFF_FFFC;
    #1;
    n_checks++; if (branch_target !== 32'h0040_0004 || pc_plus4 !== 32'h0040_0014) begin n_fail++; $display("FAIL beq_target: got tgt=%h p4=%h want 00400004/00400014", branch_target, pc_plus4); end
    tick();
    n_checks++; if (pc !== 32'h0040_0004 || flush !== 1'b1) begin n_fail++; $display("FAIL beq_redirect: got pc=%h flush=%b want 00400004/1", pc, flush); end
    idle_inputs();
    jump = 1'b1; jump_index = 26'h3FF_FFFF; branch_ne = 1'b1;
    tick();
    n_checks++; if (pc !== 32'h0040_0008 || flush !== 1'b0) begin n_fail++; $display("FAIL beq_flush_slot: got pc=%h flush=%b want 00400008/0", pc, flush); end
    n_checks++; if (taken_cnt !== 16'd1 || branch_cnt !== 16'd1) begin n_fail++; $display("FAIL beq_counts: got taken=%0d branch=%0d want 1/1", taken_cnt, branch_cnt); end
    idle_inputs();
  endtask

  task automatic test_bne_jump();
    branch_ne = 1'b1; zero = 1'b1;
    tick();
    n_checks++; if (pc !== 32'h0040_000C || flush !== 1'b0) begin n_fail++; $display("FAIL bne_not_taken: got pc=%h flush=%b want 0040000c/0", pc, flush); end
    n_checks++; if (branch_cnt !== 16'd2 || taken_cnt !== 16'd1) begin n_fail++; $display("FAIL bne_counts: got branch=%0d taken=%0d want 2/1", branch_cnt, taken_cnt); end
    do_reset();
    jump = 1'b1; branch_eq = 1'b1; zero = 1'b1; jump_index = 26'h000_0040; imm_ext = 32'h0000_0100;
    tick();
    n_checks++; if (pc !== 32'h0000_0100 || flush !== 1'b1) begin n_fail++; $display("FAIL jump_priority: got pc=%h flush=%b want 00000100/1", pc, flush); end
    n_checks++; if (taken_cnt !== 16'd1 || branch_cnt !== 16'd1) begin n_fail++; $display("FAIL jump_counts: got taken=%0d branch=%0d want 1/1", taken_cnt, branch_cnt); end
    idle_inputs();
    tick();
  endtask

  task automatic test_stall_flush();
    logic [31:0] tgt;
    branch_eq = 1'b1; zero = 1'b1; imm_ext = 32'd8;
    tgt = m_pc + 32'd4 + 32'd32;
    tick();
    idle_inputs();
    stall = 1'b1; branch_ne = 1'b1; jump = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (pc !== tgt || flush !== 1'b1) begin n_fail++; $display("FAIL stall_hold%0d: got pc=%h flush=%b want %h/1", i, pc, flush, tgt); end
      n_checks++; if (pc_plus4 !== tgt + 32'd4) begin n_fail++; $display("FAIL stall_p4_%0d: got %h want %h", i, pc_plus4, tgt + 32'd4); end
    end
    idle_inputs();
    tick();
    n_checks++; if (pc !== tgt + 32'd4 || flush !== 1'b0) begin n_fail++; $display("FAIL stall_release: got pc=%h flush=%b want %h/0", pc, flush, tgt + 32'd4); end
    n_checks++; if (taken_cnt !== 16'(m_t16)) begin n_fail++; $display("FAIL stall_cnt: got %0d want %0d", taken_cnt, m_t16); end
  endtask

  task automatic test_wrap();
    land_at(32'hFFFF_FFFC);
    n_checks++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_setup: got pc=%h p4=%h want fffffffc/00000000", pc, pc_plus4); end
    tick();
    n_checks++; if (pc !== 32'h0000_0000 || flush !== 1'b0) begin n_fail++; $display("FAIL wrap_pc: got pc=%h flush=%b want 00000000/0", pc, flush); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      branch_eq = 1'b1; zero = 1'b1; imm_ext = 32'($urandom_range(0, 64));
      tick();
      idle_inputs();
      tick();
    end
    n_checks++; if (taken_cnt2 !== 2'd3 || branch_cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_cnt2: got taken=%0d branch=%0d want 3/3", taken_cnt2, branch_cnt2); end
    n_checks++; if (taken_cnt !== 16'd5 || branch_cnt !== 16'd5) begin n_fail++; $display("FAIL sat_cnt16: got taken=%0d branch=%0d want 5/5", taken_cnt, branch_cnt); end
  endtask

  task automatic test_reset_mid_redirect();
    branch_ne = 1'b1; zero = 1'b0; imm_ext = 32'd20;
    tick();
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got flush=%b want 1", flush); end
    idle_inputs();
    rst_n = 1'b0; branch_eq = 1'b1; zero = 1'b1; stall = 1'b1;
    tick();
    n_checks++; if (pc !== RST_PC || flush !== 1'b0) begin n_fail++; $display("FAIL midrst_pc: got pc=%h flush=%b want %h/0", pc, flush, RST_PC); end
    n_checks++; if (branch_cnt !== 16'd0 || taken_cnt !== 16'd0 || taken_cnt2 !== 2'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d/%0d/%0d want 0/0/0", branch_cnt, taken_cnt, taken_cnt2); end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [31:0] want_pc;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst_n      = ($urandom_range(0, 60) != 0);
      stall      = ($urandom_range(0, 3) == 0);
      branch_eq  = ($urandom_range(0, 3) == 0);
      branch_ne  = ($urandom_range(0, 3) == 0);
      zero       = 1'($urandom);
      jump       = ($urandom_range(0, 7) == 0);
      jump_index = 26'($urandom);
      imm_ext    = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : $urandom;
      #1;
      n_checks++; if (pc_plus4 !== m_pc + 32'd4 || branch_target !== exp_branch(m_pc, imm_ext)) begin n_fail++; $display("FAIL rnd_comb%0d: got p4=%h tgt=%h want %h/%h", i, pc_plus4, branch_target, m_pc + 32'd4, exp_branch(m_pc, imm_ext)); end
      tick();
      exp_q.push_back(m_pc);
      want_pc = exp_q.pop_front();
      n_checks++; if (pc !== want_pc || pc2 !== want_pc || flush !== m_flush || flush2 !== m_flush) begin n_fail++; $display("FAIL rnd_pc%0d: got pc=%h pc2=%h flush=%b want %h/%b", i, pc, pc2, flush, want_pc, m_flush); end
      n_checks++; if (branch_cnt !== 16'(m_b16) || taken_cnt !== 16'(m_t16) || branch_cnt2 !== 2'(m_b2) || taken_cnt2 !== 2'(m_t2)) begin n_fail++; $display("FAIL rnd_cnt%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i, branch_cnt, taken_cnt, branch_cnt2, taken_cnt2, m_b16, m_t16, m_b2, m_t2); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_pc = '0; m_flush = 1'b0; m_b16 = 0; m_t16 = 0; m_b2 = 0; m_t2 = 0;
    test_reset();
    test_taken_beq();
    test_bne_jump();
    test_stall_flush();
    test_wrap();
    test_saturation();
    test_reset_mid_redirect();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
